// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    LWAIT,
    DONE
  } lsu_state_t;

  // Stores only have signed encodings; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering for the LSU: builds the two-word write mask and shifted
// store data, flags word-crossing accesses, and extracts/extends load data.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [7:0]  mask,
  output logic [63:0] wdata_sh,
  output logic        split,
  output logic [31:0] rdata
);

  logic [7:0]  base_mask;
  logic [4:0]  bit_sh;
  logic [31:0] rd_win;

  assign bit_sh = {offset, 3'b000};

  // Lane mask over the two-word window; upper nibble belongs to the next word.
  always_comb begin
    case (funct3[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    mask     = base_mask << offset;
    split    = |mask[7:4];
    wdata_sh = {32'b0, wdata} << bit_sh;
  end

  // Load extraction: slide the {hi, lo} window down, then size and extend.
  always_comb begin
    rd_win = 32'({hi, lo} >> bit_sh);
    case (funct3)
      F3_B:    rdata = {{24{rd_win[7]}}, rd_win[7:0]};
      F3_H:    rdata = {{16{rd_win[15]}}, rd_win[15:0]};
      F3_W:    rdata = rd_win;
      F3_BU:   rdata = {24'b0, rd_win[7:0]};
      F3_HU:   rdata = {16'b0, rd_win[15:0]};
      default: rdata = 32'b0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one byte-addressed RV32 access per handshake,
// issues one or two word accesses to data memory and returns the response.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;

  logic [7:0]  lane_mask;
  logic [63:0] lane_wdata;
  logic        lane_split;
  logic [31:0] lane_rdata;
  logic [31:0] lane_hi;
  logic [31:0] lane_lo;
  logic [29:0] word0;
  logic [29:0] word1;

  // An unsplit load has only one word, taken straight from memory.
  assign lane_hi = lane_split ? mem_rdata : 32'b0;
  assign lane_lo = lane_split ? lo_q : mem_rdata;
  assign word0   = addr_q[31:2];
  assign word1   = addr_q[31:2] + 30'd1;

  lsu_lane u_lane (
    .funct3   (f3_q),
    .offset   (addr_q[1:0]),
    .wdata    (wdata_q),
    .hi       (lane_hi),
    .lo       (lane_lo),
    .mask     (lane_mask),
    .wdata_sh (lane_wdata),
    .split    (lane_split),
    .rdata    (lane_rdata)
  );

  // Next-state and register-update logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'b0;
          err_d   = !f3_legal(req_we, req_funct3);
          state_d = f3_legal(req_we, req_funct3) ? ACC0 : DONE;
        end
      end
      ACC0: begin
        if (lane_split)  state_d = ACC1;
        else if (!we_q)  state_d = LWAIT;
        else             state_d = DONE;
      end
      ACC1: begin
        if (!we_q) lo_d = mem_rdata;
        state_d = we_q ? DONE : LWAIT;
      end
      LWAIT: begin
        rdata_d = lane_rdata;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state and the response register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request datapath; only observed while the state says it is meaningful.
  always_ff @(posedge clk) begin
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    lo_q    <= lo_d;
  end

  // Memory and handshake outputs decoded purely from registered state.
  always_comb begin
    mem_addr  = 32'b0;
    mem_wdata = 32'b0;
    mem_wmask = 4'b0;
    mem_we    = 1'b0;
    case (state_q)
      ACC0: begin
        mem_addr  = {2'b00, word0};
        mem_wmask = lane_mask[3:0];
        mem_we    = we_q;
        mem_wdata = we_q ? lane_wdata[31:0] : 32'b0;
      end
      ACC1: begin
        mem_addr  = {2'b00, word1};
        mem_wmask = lane_mask[7:4];
        mem_we    = we_q;
        mem_wdata = we_q ? lane_wdata[63:32] : 32'b0;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = rdata_q;

endmodule
